// File: rtl/seq_change_monitor.sv
// seq_change_monitor
// Watches CHANNELS independent WIDTH-bit sequences. A new value is accepted
// only after it has been sampled unchanged on STABLE_CYCLES+1 consecutive
// edges. Each accepted change raises a registered one-cycle pulse. The block
// also keeps sticky per-channel flags, a saturating event counter and a
// per-channel "accepted value is zero" flag.
module seq_change_monitor #(
    parameter int WIDTH          = 2,
    parameter int CHANNELS       = 4,
    parameter int STABLE_CYCLES  = 2,
    parameter int ZERO_IS_CHANGE = 0,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] seq_in,
    input  logic                      clear,
    output logic [CHANNELS-1:0]       chg_pulse,
    output logic                      chg_any,
    output logic [CHANNELS-1:0]       chg_sticky,
    output logic [CNT_WIDTH-1:0]      chg_count,
    output logic [CHANNELS-1:0]       zero_flag,
    output logic [CHANNELS*WIDTH-1:0] acc_val
);

    // Stability counter only has to reach STABLE_CYCLES-1.
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    // Popcount of one cycle's pulses: 0..CHANNELS.
    localparam int PW = $clog2(CHANNELS + 1);
    // Adder is wide enough to hold count + popcount without wrapping.
    localparam int SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

    localparam logic [CW-1:0]        CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // What one channel does on the coming edge.
    typedef enum logic [1:0] {
        ACT_HOLD,    // candidate already equals accepted value: idle
        ACT_LOAD,    // input differs from candidate: restart settling
        ACT_SETTLE,  // candidate held, still counting
        ACT_ACCEPT   // candidate held long enough: take it
    } act_e;

    // Per-channel state, packed so acc_q maps directly onto acc_val.
    logic [CHANNELS-1:0][WIDTH-1:0] cand_q, cand_d;
    logic [CHANNELS-1:0][WIDTH-1:0] acc_q,  acc_d;
    logic [CHANNELS-1:0][CW-1:0]    cnt_q,  cnt_d;
    logic [CHANNELS-1:0][WIDTH-1:0] sample;
    act_e                           act [CHANNELS];

    logic [CHANNELS-1:0]  pulse_d;
    logic [CHANNELS-1:0]  sticky_d;
    logic [CHANNELS-1:0]  zero_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic [PW-1:0]        pop_d;
    logic [SW-1:0]        sum_d;

    // Slice the flat input bus into channels and classify each channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sample[i] = seq_in[i*WIDTH +: WIDTH];
            if (sample[i] != cand_q[i])
                act[i] = ACT_LOAD;
            else if (cand_q[i] == acc_q[i])
                act[i] = ACT_HOLD;
            else if (cnt_q[i] == CNT_LAST)
                act[i] = ACT_ACCEPT;
            else
                act[i] = ACT_SETTLE;
        end
    end

    // Per-channel filter next state and pulse generation.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        cand_d  = cand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (act[i])
                ACT_LOAD: begin
                    cand_d[i] = sample[i];
                    cnt_d[i]  = '0;
                end
                ACT_SETTLE: begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
                ACT_ACCEPT: begin
                    acc_d[i]   = cand_q[i];
                    cnt_d[i]   = '0;
                    // A return to zero only counts as a change when enabled.
                    pulse_d[i] = (cand_q[i] != '0) || (ZERO_IS_CHANGE != 0);
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Sticky flags, saturating event counter and zero flags.
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < CHANNELS; i++)
            pop_d = pop_d + PW'(pulse_d[i]);

        // A set in the same cycle as clear survives the clear.
        sticky_d = (clear ? '0 : chg_sticky) | pulse_d;

        // Clear restarts the count from this cycle's events.
        sum_d   = (clear ? '0 : SW'(chg_count)) + SW'(pop_d);
        count_d = (sum_d > SW'(CNT_MAX)) ? CNT_MAX : sum_d[CNT_WIDTH-1:0];

        for (int i = 0; i < CHANNELS; i++)
            zero_d[i] = (acc_d[i] == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all filter state is reset, not just the outputs, so a
        // half-settled candidate cannot survive reset and pulse afterwards.
        if (!rst_n) begin
            cand_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            chg_pulse  <= '0;
            chg_any    <= 1'b0;
            chg_sticky <= '0;
            chg_count  <= '0;
            zero_flag  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // pre-edge values regardless of statement order.
            cand_q     <= cand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            chg_pulse  <= pulse_d;
            chg_any    <= |pulse_d;
            chg_sticky <= sticky_d;
            chg_count  <= count_d;
            zero_flag  <= zero_d;
        end
    end

    assign acc_val = acc_q;

    // chg_any is always the OR of the pulse vector it is registered with.
    a_any_matches : assert property (@(posedge clk) disable iff (!rst_n)
        chg_any == |chg_pulse);

    // A channel never pulses on two consecutive cycles.
    a_pulse_single : assert property (@(posedge clk) disable iff (!rst_n)
        (chg_pulse & $past(chg_pulse)) == '0);

endmodule

// File: tb/tb_seq_change_monitor.sv
// Testbench for seq_change_monitor. Two instances share the stimulus:
// dut_a uses the defaults (ZERO_IS_CHANGE=0, CNT_WIDTH=8), dut_b uses
// ZERO_IS_CHANGE=1 and CNT_WIDTH=3. Expected pulse events are queued when
// stimulus is driven; monitors pop and compare whenever a DUT pulses.
module tb_seq_change_monitor;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic [7:0] seq_in = 8'hFF;

    logic [3:0] a_pulse, a_sticky, a_zero;
    logic [3:0] b_pulse, b_sticky, b_zero;
    logic       a_any, b_any;
    logic [7:0] a_count, a_acc, b_acc;
    logic [2:0] b_count;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [3:0] sticky;
        logic [3:0] zero;
        logic [7:0] acc;
        logic [7:0] count;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    seq_change_monitor #(.WIDTH(2), .CHANNELS(4), .STABLE_CYCLES(2),
                         .ZERO_IS_CHANGE(0), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .clear(clear),
        .chg_pulse(a_pulse), .chg_any(a_any), .chg_sticky(a_sticky),
        .chg_count(a_count), .zero_flag(a_zero), .acc_val(a_acc)
    );

    seq_change_monitor #(.WIDTH(2), .CHANNELS(4), .STABLE_CYCLES(2),
                         .ZERO_IS_CHANGE(1), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .clear(clear),
        .chg_pulse(b_pulse), .chg_any(b_any), .chg_sticky(b_sticky),
        .chg_count(b_count), .zero_flag(b_zero), .acc_val(b_acc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic score(input string tag, input exp_t e,
                         input logic [3:0] pulse, input logic any,
                         input logic [3:0] sticky, input logic [3:0] zero,
                         input logic [7:0] acc, input logic [7:0] count);
        check({tag, "_pulse_cycle"}, 32'(cyc), 32'(e.cyc));
        check({tag, "_pulse"},  {28'b0, pulse},  {28'b0, e.pulse});
        check({tag, "_any"},    {31'b0, any},    32'd1);
        check({tag, "_sticky"}, {28'b0, sticky}, {28'b0, e.sticky});
        check({tag, "_zero"},   {28'b0, zero},   {28'b0, e.zero});
        check({tag, "_acc"},    {24'b0, acc},    {24'b0, e.acc});
        check({tag, "_count"},  {24'b0, count},  {24'b0, e.count});
    endtask

    // Monitor for dut_a.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_any || (a_pulse != 4'b0)) begin
                if (q_a.size() == 0)
                    check("a_unexpected_pulse", {27'b0, a_any, a_pulse}, 32'd0);
                else begin
                    score("a", q_a[0], a_pulse, a_any, a_sticky, a_zero,
                          a_acc, a_count);
                    q_a.delete(0);
                end
            end
            if (q_a.size() > 0 && cyc > q_a[0].cyc) begin
                check("a_missing_pulse", 32'(cyc), 32'(q_a[0].cyc));
                q_a.delete(0);
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_any || (b_pulse != 4'b0)) begin
                if (q_b.size() == 0)
                    check("b_unexpected_pulse", {27'b0, b_any, b_pulse}, 32'd0);
                else begin
                    score("b", q_b[0], b_pulse, b_any, b_sticky, b_zero,
                          b_acc, {5'b0, b_count});
                    q_b.delete(0);
                end
            end
            if (q_b.size() > 0 && cyc > q_b[0].cyc) begin
                check("b_missing_pulse", 32'(cyc), 32'(q_b[0].cyc));
                q_b.delete(0);
            end
        end
    end

    // Queue an expected pulse event, due STABLE_CYCLES+1 = 3 cycles from now.
    task automatic expect_ev(input bit to_a, input bit to_b,
                             input logic [3:0] pulse, input logic [3:0] sticky,
                             input logic [3:0] zero, input logic [7:0] acc,
                             input logic [7:0] ca, input logic [7:0] cb);
        exp_t e;
        e.cyc = cyc + 3; e.pulse = pulse; e.sticky = sticky;
        e.zero = zero;   e.acc = acc;
        if (to_a) begin e.count = ca; q_a.push_back(e); end
        if (to_b) begin e.count = cb; q_b.push_back(e); end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_pulse"},  {28'b0, a_pulse},  32'd0);
        check({tag, "_a_any"},    {31'b0, a_any},    32'd0);
        check({tag, "_a_sticky"}, {28'b0, a_sticky}, 32'd0);
        check({tag, "_a_count"},  {24'b0, a_count},  32'd0);
        check({tag, "_a_zero"},   {28'b0, a_zero},   32'd0);
        check({tag, "_a_acc"},    {24'b0, a_acc},    32'd0);
        check({tag, "_b_pulse"},  {28'b0, b_pulse},  32'd0);
        check({tag, "_b_any"},    {31'b0, b_any},    32'd0);
        check({tag, "_b_sticky"}, {28'b0, b_sticky}, 32'd0);
        check({tag, "_b_count"},  {29'b0, b_count},  32'd0);
        check({tag, "_b_zero"},   {28'b0, b_zero},   32'd0);
        check({tag, "_b_acc"},    {24'b0, b_acc},    32'd0);
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;

        // Reset held with all-ones input.
        wait_cycles(3);
        check_all_zero("reset");

        // Release with zero input: zero flags rise, no pulses.
        seq_in = 8'h00;
        rst_n  = 1'b1;
        wait_cycles(2);
        check("post_reset_a_zero", {28'b0, a_zero}, 32'hF);
        check("post_reset_b_zero", {28'b0, b_zero}, 32'hF);
        wait_cycles(3);

        // Basic change on ch0: 00 -> 01.
        seq_in = 8'h01;
        expect_ev(1, 1, 4'b0001, 4'b0001, 4'b1110, 8'h01, 8'd1, 8'd1);
        wait_cycles(5);

        // ch1: 00 -> 01.
        seq_in = 8'h05;
        expect_ev(1, 1, 4'b0010, 4'b0011, 4'b1100, 8'h05, 8'd2, 8'd2);
        wait_cycles(5);

        // Glitch on ch1: 01 -> 10 for two cycles, then back to 01.
        seq_in = 8'h09;
        wait_cycles(2);
        seq_in = 8'h05;
        wait_cycles(5);
        check("glitch_a_acc",   {24'b0, a_acc},   32'h05);
        check("glitch_a_count", {24'b0, a_count}, 32'd2);
        check("glitch_b_count", {29'b0, b_count}, 32'd2);

        // Return to zero on ch0: dut_a stays quiet, dut_b pulses.
        seq_in = 8'h04;
        expect_ev(0, 1, 4'b0001, 4'b0011, 4'b1101, 8'h04, 8'd0, 8'd3);
        wait_cycles(2);
        check("rtz_a_zero_early", {28'b0, a_zero}, 32'hC);
        wait_cycles(1);
        check("rtz_a_zero",   {28'b0, a_zero},   32'hD);
        check("rtz_a_acc",    {24'b0, a_acc},    32'h04);
        check("rtz_a_count",  {24'b0, a_count},  32'd2);
        check("rtz_a_sticky", {28'b0, a_sticky}, 32'h3);
        wait_cycles(3);

        // All channels change together; clear lands on the acceptance edge.
        seq_in = 8'hAA;
        expect_ev(1, 1, 4'hF, 4'hF, 4'h0, 8'hAA, 8'd4, 8'd4);
        wait_cycles(2);
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        wait_cycles(3);

        // Plain clear with no events.
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        wait_cycles(1);
        check("clear_a_count",  {24'b0, a_count},  32'd0);
        check("clear_a_sticky", {28'b0, a_sticky}, 32'd0);
        check("clear_b_count",  {29'b0, b_count},  32'd0);
        check("clear_b_sticky", {28'b0, b_sticky}, 32'd0);

        // Nine changes on ch0: dut_b saturates at 7, dut_a reaches 9.
        for (int k = 1; k <= 9; k++) begin
            v = (k % 2 == 1) ? 8'hA9 : 8'hAA;
            seq_in = v;
            expect_ev(1, 1, 4'b0001, 4'b0001, 4'h0, v, 8'(k),
                      (k > 7) ? 8'd7 : 8'(k));
            wait_cycles(4);
        end
        check("sat_a_count", {24'b0, a_count}, 32'd9);
        check("sat_b_count", {29'b0, b_count}, 32'd7);

        // Reset in the middle of settling.
        seq_in = 8'h55;
        wait_cycles(1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        seq_in = 8'h00;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(6);
        check("after_reset_a_zero",  {28'b0, a_zero},  32'hF);
        check("after_reset_a_count", {24'b0, a_count}, 32'd0);
        check("after_reset_a_acc",   {24'b0, a_acc},   32'd0);
        check("after_reset_b_count", {29'b0, b_count}, 32'd0);

        check("queue_a_drained", 32'(q_a.size()), 32'd0);
        check("queue_b_drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
